uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `NUM_REQ` byte-stream requesters. Sits between client blocks (command responder, status reporter, loopback path) and the single `uart_tx` instance. Grants are held for a burst of bytes framed by a `last` flag, so multi-byte messages are never interleaved on the serial line. A grant is also released after `MAX_BURST` bytes, so no single client starves the others.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `PACK_SIZE`, 8, data bits per UART packet; must match the transmitter
- `MAX_BURST`, 16, maximum bytes sent under one grant before forced re-arbitration (≥1)

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-high reset
- `req_valid`  in  NUM_REQ  requester i has a byte on its lane
- `req_data`  in  NUM_REQ*PACK_SIZE  lane i at bits [i*PACK_SIZE +: PACK_SIZE]
- `req_last`  in  NUM_REQ  byte on lane i is the final byte of its message
- `req_ready`  out  NUM_REQ  one-hot; byte accepted on lane i when `req_valid[i] & req_ready[i]`
- `tx_start`  out  1  one-cycle pulse instructing transmitter to send `tx_byte`
- `tx_byte`  out  PACK_SIZE  byte for transmitter, stable from `tx_start` until `tx_done`
- `tx_active`  in  1  transmitter busy
- `tx_done`  in  1  one-cycle pulse at end of stop bit
- `grant_id`  out  $clog2(NUM_REQ)  index of current owner (valid while `busy`)
- `busy`  out  1  a grant is held

## Operation
- States: IDLE, SEND, WAIT_DONE.
- IDLE: if any `req_valid`, choose the first set bit scanning `ptr+1, ptr+2, …` modulo NUM_REQ, where `ptr` is the last granted index (reset value NUM_REQ-1, so index 0 wins first). Register `grant_id`, set `busy`, clear `burst_cnt`, go to SEND.
- SEND: `req_ready[grant_id] = !tx_active` (combinational from state/grant); all other `req_ready` bits are 0.
  - On handshake: latch `tx_byte`, `last_r = req_last[g]`, increment `burst_cnt`, pulse `tx_start` next cycle, go to WAIT_DONE.
  - If `req_valid[g]` is low: release. Clear `busy`, set `ptr = g`, return to IDLE. A bubble ends the burst.
- WAIT_DONE: wait for `tx_done`.
  - If `last_r` or `burst_cnt == MAX_BURST`: clear `busy`, set `ptr = g`, go to IDLE.
  - Otherwise go to SEND with the same grant.
- `burst_cnt` width is $clog2(MAX_BURST+1); it saturates and never wraps.
- `req_valid` from non-granted lanes is ignored until the next IDLE arbitration. Requests arriving in the same cycle as `tx_done` are arbitrated in the following IDLE cycle.
- `tx_done` seen outside WAIT_DONE is ignored.
- Reset (any time, including mid-byte):
  - All outputs go to 0 immediately: `req_ready`, `tx_start`, `tx_byte`, `grant_id`, `busy`.
  - State → IDLE, `ptr` → NUM_REQ-1, `burst_cnt` → 0.
  - The transmitter is reset by the same `rst`.

## Timing
- Request to grant: `req_valid` high in IDLE at edge N gives `busy`/`grant_id` valid after edge N.
- `req_ready` is high during the first SEND cycle if `tx_active` is low. The handshake completes at edge N+1.
- `tx_start` is high for exactly one cycle, the cycle after the handshake. `tx_byte` changes only at a handshake.
- Byte to byte within a burst: `tx_done` at edge M gives SEND in cycle M+1 and the next handshake at the earliest at edge M+2. Inter-byte gap is 2 cycles plus serial time.
- Grant release: IDLE in cycle M+1. A new owner gets `busy` at edge M+2.
- At most one `req_ready` bit is high in any cycle, and only while `busy`.
- `tx_start` is never asserted while `tx_active` is high.

## Test plan
- Single requester, message of 3 bytes 0x41, 0x42, 0x43 (last on 0x43), transmitter model with CLK_PER_BIT=5 → `tx_start` pulses exactly 3 times with those bytes in order; `busy` drops the cycle after the third `tx_done`; `grant_id`=0 throughout.
- All 4 lanes hold 1-byte messages (lane i sends 0x10+i) continuously after reset → grant order 0,1,2,3,0,…; bytes 0x10,0x11,0x12,0x13,0x10 on `tx_byte`; no lane is granted twice before all others.
- Lane 1 sends a 20-byte message, lane 2 is pending; MAX_BURST=16 → after 16 bytes lane 2 is granted. Lane 1 resumes at byte 17 on its next grant, with no byte lost or duplicated.
- Lane 0 drops `req_valid` mid-message after 2 bytes while lane 3 is pending → grant releases in SEND; lane 3 is granted next; lane 0's later bytes are sent on its next grant.
- `tx_active` held high for 10 cycles after grant → `req_ready` and `tx_start` stay 0 until `tx_active` falls. The handshake then occurs in the first cycle with `tx_active` low.
- Assert `rst` for 1 cycle during WAIT_DONE of byte 2 of a 4-byte message → all outputs are 0 asynchronously and state returns to IDLE. After reset, lane 0 wins first and the message restarts from the requester's own resent first byte.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte-stream requesters.
// A grant lasts until the message ends, the requester stalls, or MAX_BURST bytes have gone out.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PACK_SIZE = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*PACK_SIZE-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_start,
    output logic [PACK_SIZE-1:0]         tx_byte,
    input  logic                         tx_active,
    input  logic                         tx_done,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        ptr_q, ptr_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [CW-1:0]        burst_cnt_q, burst_cnt_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 tx_start_q, tx_start_d;
    logic [PACK_SIZE-1:0] tx_byte_q, tx_byte_d;

    logic                 pick_found;
    logic [GW-1:0]        pick_idx;
    logic [GW-1:0]        cand;

    // Scan ptr+1, ptr+2, ... so the last owner is considered last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(ptr_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == SEND && !tx_active) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned and infers a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;
        busy_d      = busy_q;
        tx_start_d  = 1'b0;
        tx_byte_d   = tx_byte_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d     = pick_idx;
                    busy_d      = 1'b1;
                    burst_cnt_d = '0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (!req_valid[grant_q]) begin
                    // A bubble from the owner ends its burst.
                    busy_d  = 1'b0;
                    ptr_d   = grant_q;
                    state_d = IDLE;
                end else if (!tx_active) begin
                    tx_byte_d  = req_data[int'(grant_q)*PACK_SIZE +: PACK_SIZE];
                    last_d     = req_last[grant_q];
                    tx_start_d = 1'b1;
                    state_d    = WAIT_DONE;
                    if (burst_cnt_q != BURST_LIMIT) begin
                        burst_cnt_d = burst_cnt_q + CW'(1);
                    end
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    if (last_q || burst_cnt_q == BURST_LIMIT) begin
                        busy_d  = 1'b0;
                        ptr_d   = grant_q;
                        state_d = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= GW'(NUM_REQ - 1);
            grant_q     <= '0;
            burst_cnt_q <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_byte_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            tx_start_q  <= tx_start_d;
            tx_byte_q   <= tx_byte_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign tx_start = tx_start_q;
    assign tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester drivers, a serial transmitter model
// and a message-level round-robin model that predicts the order of transmitted bytes.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int PACK_SIZE   = 8;
    localparam int MAX_BURST   = 16;
    localparam int CLK_PER_BIT = 5;
    localparam int FRAME       = 10 * CLK_PER_BIT;
    localparam int GAP         = 70;
    localparam int GW          = $clog2(NUM_REQ);
    localparam int RUN_LIMIT   = 4000;

    typedef struct packed {
        logic [PACK_SIZE-1:0] data;
        logic                 last;
        logic                 brk;
    } item_t;

    typedef struct packed {
        logic [GW-1:0]        lane;
        logic [PACK_SIZE-1:0] data;
    } xfer_t;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*PACK_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         tx_start;
    logic [PACK_SIZE-1:0]         tx_byte;
    logic                         tx_active;
    logic                         tx_done;
    logic [GW-1:0]                grant_id;
    logic                         busy;

    logic tx_active_m;
    logic hold_active = 1'b0;
    assign tx_active = tx_active_m | hold_active;

    item_t lane_q[NUM_REQ][$];
    item_t mq[NUM_REQ][$];
    int    gap_cnt[NUM_REQ];
    xfer_t exp_q[$];
    xfer_t obs_q[$];

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .PACK_SIZE(PACK_SIZE),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .tx_start (tx_start),
        .tx_byte  (tx_byte),
        .tx_active(tx_active),
        .tx_done  (tx_done),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_obs(input string name, input int idx, input int lane, input int data);
        if (idx < obs_q.size()) begin
            check({name, "_lane"}, 32'(obs_q[idx].lane), lane);
            check({name, "_data"}, 32'(obs_q[idx].data), data);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: transfer %0d missing, only %0d observed", name, idx, obs_q.size());
        end
    endtask

    function automatic bit lanes_empty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (lane_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Message-level round robin: a burst ends on last, on a stall point, or at MAX_BURST bytes.
    function automatic void plan();
        int    ptr, g, n, c;
        bit    stop;
        item_t it;
        for (int i = 0; i < NUM_REQ; i++) mq[i] = lane_q[i];
        ptr = NUM_REQ - 1;
        while (1) begin
            g = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (ptr + k) % NUM_REQ;
                if (g < 0 && mq[c].size() > 0) g = c;
            end
            if (g < 0) break;
            n    = 0;
            stop = 1'b0;
            while (!stop) begin
                it = mq[g].pop_front();
                exp_q.push_back({GW'(g), it.data});
                n++;
                stop = it.last || it.brk || n == MAX_BURST || mq[g].size() == 0;
            end
            ptr = g;
        end
    endfunction

    task automatic load_msg(input int lane, input int base, input int len, input int brk_at);
        item_t it;
        for (int j = 0; j < len; j++) begin
            it.data = PACK_SIZE'(base + j);
            it.last = (j == len - 1);
            it.brk  = (j == brk_at);
            lane_q[lane].push_back(it);
        end
    endtask

    task automatic clear_bench();
        for (int i = 0; i < NUM_REQ; i++) begin
            lane_q[i].delete();
            gap_cnt[i] = 0;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        hold_active = 1'b0;
        clear_bench();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until_done(input string name);
        int cyc = 0;
        while (cyc < RUN_LIMIT && !(exp_q.size() == 0 && !busy && !tx_active && lanes_empty())) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_finished"}, 32'(cyc < RUN_LIMIT), 1);
        check({name, "_all_sent"}, exp_q.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    // Transmitter model: latches tx_start, stays active for a frame, then pulses tx_done.
    initial begin : txm
        logic start_s;
        int   cnt;
        tx_active_m = 1'b0;
        tx_done     = 1'b0;
        cnt         = 0;
        forever begin
            @(negedge clk);
            start_s = tx_start && !rst;
            @(posedge clk);
            #1;
            if (rst) begin
                tx_active_m = 1'b0;
                tx_done     = 1'b0;
                cnt         = 0;
            end else begin
                tx_done = 1'b0;
                if (cnt != 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        tx_active_m = 1'b0;
                        tx_done     = 1'b1;
                    end
                end else if (start_s) begin
                    tx_active_m = 1'b1;
                    cnt         = FRAME - 1;
                end
            end
        end
    end

    // Requesters: present the head of each lane queue, pop on handshake, stall after a brk item.
    initial begin : drv
        logic [NUM_REQ-1:0] hs;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            hs = rst ? '0 : (req_valid & req_ready);
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i] && lane_q[i].size() > 0) begin
                    if (lane_q[i][0].brk) gap_cnt[i] = GAP;
                    void'(lane_q[i].pop_front());
                end
                if (gap_cnt[i] > 0) begin
                    gap_cnt[i]--;
                    req_valid[i] = 1'b0;
                end else if (lane_q[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*PACK_SIZE +: PACK_SIZE] = lane_q[i][0].data;
                    req_last[i] = lane_q[i][0].last;
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Per-cycle compare against the model and the interface rules.
    initial begin : cmp
        logic                 prev_start;
        logic                 prev_hs;
        logic [PACK_SIZE-1:0] prev_byte;
        logic                 ok;
        xfer_t                e;
        prev_start = 1'b0;
        prev_hs    = 1'b0;
        prev_byte  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_start = 1'b0;
                prev_hs    = 1'b0;
                prev_byte  = '0;
            end else begin
                ok = (req_ready == '0) ||
                     (busy && !tx_active && req_ready == (NUM_REQ'(1) << grant_id));
                check("req_ready_legal", 32'(ok), 1);
                if (tx_start) begin
                    check("tx_start_while_active", 32'(tx_active), 0);
                    check("tx_start_width", 32'(prev_start), 0);
                    check("tx_start_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("grant_id", 32'(grant_id), 32'(e.lane));
                        check("tx_byte", 32'(tx_byte), 32'(e.data));
                    end
                    obs_q.push_back({grant_id, tx_byte});
                end
                if (!prev_hs) check("tx_byte_stable", 32'(tx_byte), 32'(prev_byte));
                prev_hs    = |(req_valid & req_ready);
                prev_start = tx_start;
                prev_byte  = tx_byte;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int  cyc;
        bit  found;

        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_byte", 32'(tx_byte), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_req_ready", 32'(req_ready), 0);

        // Single requester, three-byte message; busy drops right after the third tx_done.
        load_msg(0, 8'h41, 3, -1);
        plan();
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < RUN_LIMIT) begin
            @(negedge clk);
            cyc++;
            if (tx_done && obs_q.size() == 3) begin
                found = 1'b1;
                check("t1_busy_at_done", 32'(busy), 1);
                @(negedge clk);
                check("t1_busy_after_done", 32'(busy), 0);
            end
        end
        check("t1_third_done_seen", 32'(found), 1);
        run_until_done("t1");
        check("t1_count", obs_q.size(), 3);
        check_obs("t1_b0", 0, 0, 8'h41);
        check_obs("t1_b1", 1, 0, 8'h42);
        check_obs("t1_b2", 2, 0, 8'h43);

        // All lanes with one-byte messages: strict rotation 0,1,2,3,0,...
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_REQ; i++) load_msg(i, 8'h10 + i, 1, -1);
        end
        plan();
        run_until_done("t2");
        check("t2_count", obs_q.size(), 8);
        for (int k = 0; k < NUM_REQ; k++) check_obs("t2_first_round", k, k, 8'h10 + k);
        check_obs("t2_wrap", 4, 0, 8'h10);

        // Long message on lane 1 is cut at MAX_BURST; lane 2 goes next; lane 1 resumes.
        do_reset();
        load_msg(1, 8'h80, 20, -1);
        load_msg(2, 8'hC0, 2, -1);
        plan();
        run_until_done("t3");
        check("t3_count", obs_q.size(), 22);
        check_obs("t3_byte16", 15, 1, 8'h8F);
        check_obs("t3_switch", 16, 2, 8'hC0);
        check_obs("t3_resume", 18, 1, 8'h90);
        check_obs("t3_tail", 21, 1, 8'h93);

        // Lane 0 stalls after two bytes; lane 3 is served before lane 0 continues.
        do_reset();
        load_msg(0, 8'h30, 4, 1);
        load_msg(3, 8'h70, 1, -1);
        plan();
        run_until_done("t4");
        check("t4_count", obs_q.size(), 5);
        check_obs("t4_before", 1, 0, 8'h31);
        check_obs("t4_other", 2, 3, 8'h70);
        check_obs("t4_resume", 3, 0, 8'h32);

        // Transmitter busy at grant time: no ready or start until it goes idle.
        do_reset();
        hold_active = 1'b1;
        load_msg(2, 8'h5A, 1, -1);
        plan();
        @(posedge clk);
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t5_busy_held", 32'(busy), 1);
            check("t5_ready_held", 32'(req_ready), 0);
            check("t5_start_held", 32'(tx_start), 0);
        end
        @(posedge clk);
        #1;
        hold_active = 1'b0;
        @(negedge clk);
        check("t5_ready_released", 32'(req_ready), 32'h4);
        @(negedge clk);
        check("t5_start", 32'(tx_start), 1);
        check("t5_byte", 32'(tx_byte), 8'h5A);
        run_until_done("t5");

        // Reset in the middle of byte 2: outputs clear at once, message restarts on lane 0.
        do_reset();
        load_msg(0, 8'hA0, 4, -1);
        load_msg(1, 8'hB0, 1, -1);
        plan();
        cyc = 0;
        while (obs_q.size() < 2 && cyc < RUN_LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_second_byte_seen", 32'(obs_q.size()), 2);
        repeat (5) @(negedge clk);
        check("t6_pre_reset_byte", 32'(tx_byte), 8'hA1);
        check("t6_pre_reset_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("t6_async_busy", 32'(busy), 0);
        check("t6_async_tx_byte", 32'(tx_byte), 0);
        check("t6_async_tx_start", 32'(tx_start), 0);
        check("t6_async_grant_id", 32'(grant_id), 0);
        check("t6_async_req_ready", 32'(req_ready), 0);
        clear_bench();
        @(negedge clk);
        rst = 1'b0;
        load_msg(0, 8'hA0, 4, -1);
        load_msg(1, 8'hB0, 1, -1);
        plan();
        run_until_done("t6");
        check("t6_count", obs_q.size(), 5);
        check_obs("t6_restart", 0, 0, 8'hA0);
        check_obs("t6_last", 3, 0, 8'hA3);
        check_obs("t6_next_lane", 4, 1, 8'hB0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
